// File: rtl/ttfir_decimator.sv
// Integrate-and-dump decimator for the ttfir FIR output: sums R samples, scales, saturates.
// Define TTFIR_DEC_ROUND_EN for round-half-up scaling instead of floor truncation.
module ttfir_decimator #(
  parameter int BW_in  = 8,
  parameter int BW_out = 8,
  parameter int LOG2_R = 2,
  parameter int SHIFT  = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [BW_in-1:0]  x_in,
  input  logic                     x_valid,
  input  logic                     dec_sync,
  input  logic                     sat_clr,
  output logic signed [BW_out-1:0] y_dec,
  output logic                     y_valid,
  output logic                     sat_flag,
  output logic [LOG2_R-1:0]        phase
);

  localparam int ACC_W = BW_in + LOG2_R;
  localparam int EXT_W = ACC_W + 1;
  localparam logic [LOG2_R-1:0] LAST_PH = '1;
  localparam int Y_MAX = (1 << (BW_out - 1)) - 1;
  localparam int Y_MIN = -(1 << (BW_out - 1));

  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [LOG2_R-1:0]        phase_q, phase_d;
  logic signed [BW_out-1:0] y_q, y_d;
  logic                     y_valid_q, y_valid_d;
  logic                     sat_q, sat_d;

  logic signed [ACC_W-1:0]  base;
  logic signed [ACC_W-1:0]  sum;
  logic [LOG2_R-1:0]        phase_eff;
  logic                     dump;
  logic signed [EXT_W-1:0]  sum_w;
  logic signed [EXT_W-1:0]  scaled;
  logic                     clip_hi, clip_lo;
  logic signed [BW_out-1:0] y_sat;

  // A frame restart behaves as if the accumulator and phase were already zero.
  assign base      = dec_sync ? '0 : acc_q;
  assign phase_eff = dec_sync ? '0 : phase_q;
  assign sum       = base + {{LOG2_R{x_in[BW_in-1]}}, x_in};
  assign dump      = x_valid && (phase_eff == LAST_PH);
  assign sum_w     = {sum[ACC_W-1], sum};

`ifdef TTFIR_DEC_ROUND_EN
  generate
    if (SHIFT > 0) begin : g_round
      localparam logic [EXT_W-1:0] HALF = EXT_W'(1) << (SHIFT - 1);
      assign scaled = (sum_w + $signed(HALF)) >>> SHIFT;
    end else begin : g_trunc
      assign scaled = sum_w;
    end
  endgenerate
`else
  assign scaled = sum_w >>> SHIFT;
`endif

  assign clip_hi = scaled > Y_MAX;
  assign clip_lo = scaled < Y_MIN;
  assign y_sat   = clip_hi ? BW_out'(Y_MAX) :
                   clip_lo ? BW_out'(Y_MIN) : BW_out'(scaled);

  always_comb begin
    acc_d     = acc_q;
    phase_d   = phase_q;
    y_d       = y_q;
    y_valid_d = 1'b0;
    sat_d     = sat_q & ~sat_clr;
    if (x_valid) begin
      if (dump) begin
        acc_d     = '0;
        phase_d   = '0;
        y_d       = y_sat;
        y_valid_d = 1'b1;
        if (clip_hi || clip_lo) sat_d = 1'b1;
      end else begin
        acc_d   = sum;
        phase_d = phase_eff + LOG2_R'(1);
      end
    end else if (dec_sync) begin
      acc_d   = '0;
      phase_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q     <= '0;
      phase_q   <= '0;
      y_q       <= '0;
      y_valid_q <= 1'b0;
      sat_q     <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      phase_q   <= phase_d;
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
      sat_q     <= sat_d;
    end
  end

  assign y_dec    = y_q;
  assign y_valid  = y_valid_q;
  assign sat_flag = sat_q;
  assign phase    = phase_q;

endmodule

// File: tb/tb_ttfir_decimator.sv
// Scoreboard bench for ttfir_decimator: a frame-list reference model queues expected
// outputs, and a negedge monitor compares them whenever the DUT strobes y_valid.
module tb_ttfir_decimator;
  localparam int BW_IN  = 8;
  localparam int BW_OUT = 8;
  localparam int LOG2_R = 2;
  localparam int SHIFT  = 1;
  localparam int R      = 1 << LOG2_R;
  localparam int Y_MAX  = (1 << (BW_OUT - 1)) - 1;
  localparam int Y_MIN  = -(1 << (BW_OUT - 1));

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                     rst = 1'b1;
  logic signed [BW_IN-1:0]  x_in = '0;
  logic                     x_valid = 1'b0;
  logic                     dec_sync = 1'b0;
  logic                     sat_clr = 1'b0;
  logic signed [BW_OUT-1:0] y_dec;
  logic                     y_valid;
  logic                     sat_flag;
  logic [LOG2_R-1:0]        phase;

  ttfir_decimator #(.BW_in(BW_IN), .BW_out(BW_OUT), .LOG2_R(LOG2_R), .SHIFT(SHIFT)) dut (
    .clk(clk), .rst(rst), .x_in(x_in), .x_valid(x_valid), .dec_sync(dec_sync),
    .sat_clr(sat_clr), .y_dec(y_dec), .y_valid(y_valid), .sat_flag(sat_flag), .phase(phase)
  );

  int checks = 0;
  int errors = 0;
  int exp_y_q[$];
  bit exp_sat_q[$];
  int frame[$];
  bit m_sat = 1'b0;
  bit started = 1'b0;
  bit rst_seen = 1'b0;
  int last_y = 0;
  int n_out = 0;

  task automatic check(string name, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: a frame is simply the list of accepted samples; it dumps when R are collected.
  task automatic model_edge(bit r, bit v, int x, bit sync, bit clr);
    int sum, s, y;
    bit clipped;
    if (r) begin
      frame.delete();
      m_sat = 1'b0;
      return;
    end
    clipped = 1'b0;
    if (v) begin
      if (sync) frame.delete();
      frame.push_back(x);
      if (frame.size() == R) begin
        sum = 0;
        foreach (frame[i]) sum += frame[i];
`ifdef TTFIR_DEC_ROUND_EN
        if (SHIFT > 0) s = (sum + (1 << (SHIFT - 1))) >>> SHIFT;
        else s = sum;
`else
        s = sum >>> SHIFT;
`endif
        if (s > Y_MAX) y = Y_MAX;
        else if (s < Y_MIN) y = Y_MIN;
        else y = s;
        clipped = (y != s);
        frame.delete();
        m_sat = (m_sat && !clr) || clipped;
        exp_y_q.push_back(y);
        exp_sat_q.push_back(m_sat);
        return;
      end
    end else if (sync) begin
      frame.delete();
    end
    m_sat = m_sat && !clr;
  endtask

  task automatic step(bit v, int x, bit sync = 1'b0, bit clr = 1'b0, bit r = 1'b0);
    int xv;
    xv = x;
    rst      = r;
    x_valid  = v;
    x_in     = xv[BW_IN-1:0];
    dec_sync = sync;
    sat_clr  = clr;
    @(posedge clk);
    model_edge(r, v, $signed(xv[BW_IN-1:0]), sync, clr);
    #1;
    check("phase", int'(phase), frame.size());
    check("sat_flag", int'(sat_flag), int'(m_sat));
  endtask

  task automatic feed(int x, int n);
    for (int i = 0; i < n; i++) step(1'b1, x);
  endtask

  always @(posedge clk) rst_seen <= rst;

  always @(negedge clk) begin
    if (started) begin
      if (rst_seen) begin
        check("rst_y_valid", int'(y_valid), 0);
        check("rst_y_dec", int'(y_dec), 0);
        last_y = 0;
      end else if (y_valid === 1'b1) begin
        if (exp_y_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_y_valid: got y_dec=%0d, expected no output", y_dec);
        end else begin
          int ey;
          bit es;
          ey = exp_y_q.pop_front();
          es = exp_sat_q.pop_front();
          n_out++;
          $display("out %0d: y_dec=%0d expected %0d sat_flag=%0b", n_out, y_dec, ey, sat_flag);
          check("y_dec", int'(y_dec), ey);
          check("dump_sat_flag", int'(sat_flag), int'(es));
          last_y = ey;
        end
      end else begin
        check("y_valid_low", int'(y_valid), 0);
        check("y_dec_hold", int'(y_dec), last_y);
      end
    end
  end

  initial begin
    rst = 1'b1;
    @(posedge clk);
    started = 1'b1;
    step(1'b0, 0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 0);

    // basic frame, then rounding-sensitive frame
    feed(10, 1); feed(20, 1); feed(30, 1); feed(40, 1);
    step(1'b0, 0);
    feed(1, 3); feed(0, 1);
    step(1'b0, 0);

    // saturation both directions, then clear
    feed(127, 4);
    step(1'b0, 0);
    feed(-128, 4);
    step(1'b0, 0);
    step(1'b0, 0, 1'b0, 1'b1);
    step(1'b0, 0);

    // gapped valid pattern 1,0,0,1,0,1,1
    step(1'b1, 8); step(1'b0, 8); step(1'b0, 8); step(1'b1, 8);
    step(1'b0, 8); step(1'b1, 8); step(1'b1, 8);
    step(1'b0, 0); step(1'b0, 0); step(1'b0, 0);

    // restart mid-frame with a sample, then restart alone at the last phase
    feed(100, 2);
    step(1'b1, 4, 1'b1);
    feed(4, 3);
    step(1'b0, 0);
    feed(7, 3);
    step(1'b0, 0, 1'b1);
    step(1'b0, 0);

    // reset mid-frame
    feed(50, 3);
    step(1'b0, 0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 0);
    feed(2, 4);
    step(1'b0, 0);

    // randomized traffic with occasional restarts, clears and resets
    for (int i = 0; i < 600; i++) begin
      int x;
      bit v, sy, cl, rs;
      case ($urandom_range(0, 5))
        0: x = Y_MAX;
        1: x = -128;
        default: x = int'($urandom_range(0, 255)) - 128;
      endcase
      v  = ($urandom_range(0, 3) != 0);
      sy = ($urandom_range(0, 15) == 0);
      cl = ($urandom_range(0, 11) == 0);
      rs = ($urandom_range(0, 79) == 0);
      step(v, x, sy, cl, rs);
    end

    step(1'b0, 0); step(1'b0, 0); step(1'b0, 0);
    check("pending_outputs", exp_y_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ttfir_decimator.md
Name: ttfir_decimator

Overview:
- Integrate-and-dump decimator directly downstream of the ttfir FIR core. Consumes the FIR's signed output samples.
- Sums R consecutive accepted samples, scales by 2^-SHIFT, saturates to BW_out and presents one decimated sample per frame with a one-cycle valid strobe.
- Reduces output rate on the shared 8-bit TinyTapeout output bus. Flags any clipping in a sticky status bit.

Parameters:
- BW_in, 8, signed input sample width; matches FIR BW_out.
- BW_out, 8, signed output sample width.
- LOG2_R, 2, log2 of decimation ratio; R = 2^LOG2_R samples per frame; legal range 1..4.
- SHIFT, 1, right-shift (arithmetic) applied to the frame sum before saturation; legal range 0..BW_in+LOG2_R-1.

Ports:
- clk, input, 1, sole clock; all state updates on rising edge.
- rst, input, 1, synchronous active-high reset.
- x_in, input, BW_in, signed sample from FIR.
- x_valid, input, 1, x_in is accepted on any rising edge with x_valid=1.
- dec_sync, input, 1, frame restart: discards partial sum; phase returns to 0.
- sat_clr, input, 1, clears sticky sat_flag.
- y_dec, output, BW_out, signed decimated sample; held between frames.
- y_valid, output, 1, one-cycle strobe: new y_dec this cycle.
- sat_flag, output, 1, sticky: some frame result was clipped.
- phase, output, LOG2_R, index of next sample within the frame (0..R-1).

Behaviour:
- Reset (rst=1 at edge): acc=0, phase=0, y_dec=0, y_valid=0, sat_flag=0. Reset has priority over all other inputs.
- Accumulator: signed, width BW_in+LOG2_R. Sign-extend x_in; no overflow possible.
- Accept with phase<R-1: acc <= acc+x_in; phase <= phase+1.
- Accept with phase==R-1 (dump):
  - sum = acc+x_in; s = sum >>> SHIFT (floor).
  - y_dec <= sat(s), clipped to [-2^(BW_out-1), 2^(BW_out-1)-1].
  - y_valid <= 1 for exactly the next cycle.
  - acc <= 0; phase <= 0.
  - If clipped, sat_flag <= 1.
- Latency: y_dec/y_valid are registered and visible the cycle after the edge that accepted the R-th sample.
- x_valid=0: acc and phase hold; y_valid deasserts after its one cycle; y_dec holds.
- dec_sync=1 without x_valid: acc <= 0, phase <= 0, no output.
- dec_sync=1 with x_valid:
  - Partial sum is discarded; x_in becomes sample 0 of the new frame: acc <= sext(x_in), phase <= 1.
  - When R=1 this is an immediate dump of x_in alone.
  - dec_sync never produces y_valid for the discarded frame.
- sat_clr and a clipping dump on the same edge: set wins, sat_flag=1.
- Reset mid-frame: partial sum lost. The first frame after reset starts at the first accepted sample.
- No backpressure: a consumer must take y_dec while y_valid=1 or before the next dump.

Optional Feature:
- Macro TTFIR_DEC_ROUND_EN.
- Defined and SHIFT>0: s = (sum + 2^(SHIFT-1)) >>> SHIFT, round-half-up, computed in width BW_in+LOG2_R+1 before saturation.
- Undefined, or SHIFT=0: pure truncation (floor) as above.

Test Plan:
- Defaults, continuous x_valid, x_in=10,20,30,40 -> one cycle after 4th sample: y_valid=1, y_dec=50, sat_flag=0, phase=0.
- x_in=1,1,1,0 -> y_dec=1 without TTFIR_DEC_ROUND_EN, y_dec=2 with it.
- Saturation: four samples of 127 -> sum 508, >>1=254 -> y_dec=127, sat_flag=1. Four of -128 -> y_dec=-128. Pulse sat_clr -> sat_flag=0.
- Gapped input: x_in=8 with x_valid pattern 1,0,0,1,0,1,1 -> exactly one y_valid, y_dec=16. phase holds during gaps; y_dec holds afterwards.
- dec_sync:
  - Feed 100,100 (phase=2), then dec_sync+x_valid with x_in=4, then 4,4,4 -> y_dec=8, no output for the aborted frame.
  - dec_sync alone at phase=3 -> phase=0, no strobe.
- Reset mid-frame: 3 samples of 50, rst one cycle, then 2,2,2,2 -> y_dec=4. All outputs 0 during and immediately after reset.
